// File: rtl/flit_arbiter.sv
// Wormhole flit arbiter: round-robin port selection, lock held for a whole packet,
// with an idle-lock timeout that aborts a stalled owner.

package types;
    typedef enum logic [1:0] {
        NOPE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2,
        TAIL = 2'd3
    } flittype_t;

    typedef struct packed {
        flittype_t  flittype;
        logic [3:0] dest;
    } header_t;

    typedef struct packed {
        header_t     header;
        logic [31:0] payload;
    } flit_t;
endpackage

module flit_arbiter #(
    parameter int unsigned NUM_PORTS    = 4,
    parameter int unsigned LOCK_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  types::flit_t         in_flit [NUM_PORTS],
    input  logic [NUM_PORTS-1:0] in_valid,
    output logic [NUM_PORTS-1:0] in_ready,
    output types::flit_t         out_flit,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUM_PORTS-1:0] grant,
    output logic                 timeout_err
);
    localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned CW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   last_grant;
    logic [PW-1:0]   winner;
    logic [CW-1:0]   cnt;
    logic            xfer;
    logic            last_flit;

    // Round-robin pick: first valid port after last_grant, wrapping; last_grant itself lowest.
    always_comb begin : rr_pick
        logic [PW-1:0] idx;
        logic          found;
        idx    = '0;
        found  = 1'b0;
        winner = last_grant;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            idx = PW'((32'(last_grant) + i) % NUM_PORTS);
            if (!found && in_valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Owner's flit passes straight through to the router while locked.
    always_comb begin : datapath
        out_flit  = '0;
        out_valid = 1'b0;
        in_ready  = '0;
        if (state == LOCKED) begin
            out_flit        = in_flit[owner];
            out_valid       = in_valid[owner];
            in_ready[owner] = out_ready;
        end
    end

    assign xfer      = out_valid & out_ready;
    assign last_flit = (out_flit.header.flittype == types::TAIL) ||
                       (out_flit.header.flittype == types::NOPE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            owner       <= '0;
            last_grant  <= PW'(NUM_PORTS - 1);
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            if (state == IDLE) begin
                if (|in_valid) begin
                    state <= LOCKED;
                    owner <= winner;
                    grant <= NUM_PORTS'(1) << winner;
                    cnt   <= '0;
                end
            end else if (xfer) begin
                cnt <= '0;
                if (last_flit) begin
                    state      <= IDLE;
                    grant      <= '0;
                    last_grant <= owner;
                end
            end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                // This idle cycle brings the counter to LOCK_TIMEOUT: abandon the packet.
                state       <= IDLE;
                grant       <= '0;
                last_grant  <= owner;
                cnt         <= '0;
                timeout_err <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule
